out_uart_logger: RTL and testbench
==================================

Name: out_uart_logger

Overview:
- Downstream consumer of the RV_CPU 10-bit `out` bus.
- Detects every change of the bus value, buffers each new value in a small FIFO, and serialises it over a UART 8N1 TX line.
- Gives bench and board a cycle-independent log of CPU output activity.
- Sits beside the CPU under the same `clk` and `reset`.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range ≥ 2.
- DEPTH, 8: FIFO entries of 10 bits each; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_out  input  10  CPU output bus (connects to RV_CPU `out`).
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while the TX FSM is not in IDLE.
- overflow  output  1  sticky; a change was dropped because the FIFO was full.
- fifo_level  output  $clog2(DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high. On any edge with reset=1:
  - tx=1, busy=0, overflow=0, fifo_level=0.
  - prev_q=0, FIFO pointers cleared, FSM=IDLE.
  - Any frame in flight is abandoned immediately.
- Change detect:
  - prev_q is registered from cpu_out every edge.
  - A push is requested on an edge where cpu_out != prev_q.
  - After reset, a first nonzero cpu_out is therefore captured; cpu_out held at 0 produces nothing.
- FIFO write:
  - A push is accepted if fifo_level < DEPTH, or if a pop occurs on the same edge.
  - Otherwise the value is dropped and overflow is set to 1 and held until reset.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- Word framing: each 10-bit word d is sent as two bytes, back to back.
  - byte0 = {4'hA, 2'b00, d[9:8]}; the upper nibble A is a sync marker.
  - byte1 = d[7:0].
- Bit format per byte:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - One word = 20·CLKS_PER_BIT cycles of tx activity.
- FSM states: IDLE, START, DATA, STOP, plus a byte-select flag (0 = byte0, 1 = byte1).
  - IDLE: tx=1. If fifo_level > 0, pop the head word into a shift holding register on that edge → START, byte_sel=0.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: tx = current bit. Bit index advances 0..7, each held CLKS_PER_BIT cycles. After bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_sel=0: → START with byte_sel=1 (no idle gap).
    - Else: → IDLE.
- Latency:
  - Push on edge E makes fifo_level=1 after E.
  - If the FSM is in IDLE, the pop occurs on edge E+1 and tx falls after E+1.
  - Between consecutive words there is exactly one IDLE cycle (tx=1) before the next start bit.
- busy = (state != IDLE), registered alongside state.
- Bit-timer counter width is $clog2(CLKS_PER_BIT); it reloads at every bit boundary with no drift.
- cpu_out changes during transmission never disturb the word in flight. They only push into the FIFO.
- Changes faster than one per cycle cannot occur. Each differing edge is one push, including toggling back to a previous value.

Test Plan:
- CLKS_PER_BIT=4. Reset 10 cycles, then cpu_out 0→0x2A5 and hold → one push. tx decodes bytes 0xA2 then 0xA5. The first start bit falls 2 edges after the change is sampled. busy is high for exactly 80 cycles. fifo_level returns to 0.
- Hold cpu_out=0 for 500 cycles after reset → tx constant 1, busy=0, fifo_level=0, overflow=0.
- DEPTH=8, CLKS_PER_BIT=4. Drive 10 distinct values on consecutive cycles (0x001..0x00A) → first word popped after 0x001 is pushed. 9 further values arrive, the FIFO fills to 8, and the last value 0x00A is dropped. Required: overflow=1 and sticky; decoded stream is 0x001..0x009 in order.
- Two changes 0x3FF then 0x000 spaced 200 cycles → two complete words (0xA3,0xFF) then (0xA0,0x00). tx has at least one idle-high cycle between frames.
- Reset asserted mid-DATA of byte1 → on the reset edge tx=1, busy=0, fifo_level=0, overflow=0. The next change after reset transmits cleanly with no remnant bits.
- Push and pop on the same edge with the FIFO full → fifo_level stays at DEPTH and overflow stays 0.

Source files
------------

// File: rtl/out_uart_logger.sv
// rtl/out_uart_logger.sv - logs every change of the CPU out bus over a UART 8N1 line
// Each new value is queued and sent as a marker byte {A,00,d[9:8]} followed by d[7:0].
module out_uart_logger #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 cpu_out,
  output logic                       tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [9:0]      prev_q;
  logic [9:0]      word_q;
  logic [7:0]      sh;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic            byte_sel;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  logic            push;
  logic            pop;
  logic            accept;

  assign push   = (cpu_out != prev_q);
  assign pop    = (state == IDLE) && (fifo_level != '0);
  // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts.
  assign accept = push && ((fifo_level < L_FULL) || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= cpu_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_q <= cpu_out;
      if (accept) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && !accept) overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      word_q   <= '0;
      sh       <= '0;
      timer    <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            word_q   <= mem[rptr];
            sh       <= {4'hA, 2'b00, mem[rptr][9:8]};
            byte_sel <= 1'b0;
            timer    <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (timer == T_LAST) begin
            timer   <= '0;
            tx      <= sh[0];
            sh      <= {1'b0, sh[7:1]};
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= sh[0];
              sh      <= {1'b0, sh[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (!byte_sel) begin
              // Low byte follows the marker byte with no idle gap.
              byte_sel <= 1'b1;
              sh       <= word_q[7:0];
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart_logger.sv
// tb/tb_out_uart_logger.sv - randomized and directed bench for out_uart_logger
// Reference model: a word queue plus a frame-position counter; tx is computed from frame arithmetic.
module tb_out_uart_logger;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 20 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cpu_out = '0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [3:0] fifo_level;

  out_uart_logger #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_out    (cpu_out),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [9:0] m_q[$];
  logic [9:0] m_prev = '0;
  logic [9:0] m_word = '0;
  int         m_rem = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_prev = '0;
      m_rem  = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_rem > 0) m_rem--;
      else if (m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_rem  = FRAME;
        exp_q.push_back({4'hA, 2'b00, m_word[9:8]});
        exp_q.push_back(m_word[7:0]);
      end
      if (cpu_out != m_prev) begin
        if (m_q.size() < DEPTH) m_q.push_back(cpu_out);
        else m_ovf = 1'b1;
      end
      m_prev = cpu_out;
    end
  end

  function automatic logic m_tx();
    int pos, b, k;
    logic [7:0] byt;
    if (m_rem == 0) return 1'b1;
    pos = FRAME - m_rem;
    b   = pos / CPB;
    k   = b % 10;
    byt = (b < 10) ? {4'hA, 2'b00, m_word[9:8]} : m_word[7:0];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return byt[k-1];
  endfunction

  always @(negedge clk) begin
    check("tx", tx, m_tx());
    check("busy", busy, m_rem > 0);
    check("level", fifo_level, m_q.size());
    check("overflow", overflow, m_ovf);
  end

  // UART receiver: samples each bit one cycle after its start
  bit         dec_act = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = '0;

  always @(negedge clk) begin
    if (!busy) dec_act = 0;
    else if (!dec_act) begin
      if (tx == 1'b0) begin
        dec_act = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == 9 * CPB + 1) begin
        check("stop_bit", tx, 1'b1);
        dec_q.push_back(dec_byte);
        dec_act = 0;
      end else if (dec_cnt > CPB && dec_cnt % CPB == 1) begin
        dec_byte[dec_cnt / CPB - 1] = tx;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    dec_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_len"}, dec_q.size(), exp_q.size());
    n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, dec_q[i], exp_q[i]);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] want[$]);
    check({tag, "_len"}, dec_q.size(), want.size());
    for (int i = 0; i < want.size() && i < dec_q.size(); i++)
      check({tag, "_byte"}, dec_q[i], want[i]);
  endtask

  initial begin
    int k;
    int bc;
    logic [7:0] want[$];

    cpu_out = '0;
    do_reset(10);

    // bus held at zero: no activity
    tick(500);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_level", fifo_level, 0);
    check("idle_ovf", overflow, 1'b0);

    // single word 0x2A5
    clear_logs();
    cpu_out = 10'h2A5;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      k++;
      if (tx == 1'b0) break;
    end
    check("first_start_latency", k, 2);
    bc = busy ? 1 : 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (busy) bc++;
    end
    check("busy_cycles", bc, FRAME);
    check("single_level", fifo_level, 0);
    want = '{8'hA2, 8'hA5};
    check_bytes("single", want);

    // overflow on 10 back-to-back changes
    do_reset(2);
    clear_logs();
    for (int v = 1; v <= 10; v++) begin
      cpu_out = 10'(v);
      tick(1);
    end
    check("fill_level", fifo_level, DEPTH);
    check("ovf_set", overflow, 1'b1);
    tick(9 * (FRAME + 1) + 40);
    check("ovf_sticky", overflow, 1'b1);
    want.delete();
    for (int v = 1; v <= 9; v++) begin
      want.push_back(8'hA0);
      want.push_back(8'(v));
    end
    check_bytes("ovf_stream", want);

    // push and pop on the same edge with the FIFO full
    do_reset(2);
    clear_logs();
    for (int v = 1; v <= 9; v++) begin
      cpu_out = 10'h100 + 10'(v);
      tick(1);
    end
    check("full_level", fifo_level, DEPTH);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1);
      if (!busy) break;
    end
    check("wait_idle", busy, 1'b0);
    cpu_out = 10'h1FF;
    tick(1);
    check("pushpop_level", fifo_level, DEPTH);
    check("pushpop_ovf", overflow, 1'b0);
    tick(10 * (FRAME + 1) + 40);
    check("pushpop_count", dec_q.size(), 20);
    check_stream("pushpop");

    // two spaced changes
    do_reset(2);
    clear_logs();
    cpu_out = 10'h3FF;
    tick(200);
    cpu_out = 10'h000;
    tick(200);
    want = '{8'hA3, 8'hFF, 8'hA0, 8'h00};
    check_bytes("spaced", want);

    // reset mid-DATA of the low byte
    do_reset(2);
    clear_logs();
    cpu_out = 10'h155;
    tick(2 + 14 * CPB);
    check("midframe_busy", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    clear_logs();
    cpu_out = 10'h0C3;
    tick(FRAME + 20);
    want = '{8'hA0, 8'hC3};
    check_bytes("after_rst", want);

    // randomized bursts and gaps
    do_reset(2);
    clear_logs();
    repeat (40) begin
      repeat ($urandom_range(1, 4)) begin
        cpu_out = 10'($urandom_range(0, 1023));
        tick(1);
      end
      tick($urandom_range(0, 150));
    end
    tick(DEPTH * (FRAME + 1) + 2 * FRAME);
    check_stream("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
